// File: rtl/cpc_host_fifo_ctrl.sv
// Host (CPC) side sequencer for the bidirectional FIFO link.
// Decodes Z80 I/O cycles at a two-port window: the data port pushes or
// pops FIFO words, and the status/control port reports flags or triggers
// a FIFO master reset. All outputs come straight from registers.
module cpc_host_fifo_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'hFD80,
    parameter int          SI_WIDTH  = 2,
    parameter int          SOB_WIDTH = 2,
    parameter int          MR_WIDTH  = 4
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        fifo_host_dir,
    input  logic        fifo_host_dor,
    input  logic        fifo_slave_dir,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        host_fifo_si,
    output logic        host_fifo_sob,
    output logic        host_fifo_oeb,
    output logic        host_fifo_reset
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        RD_DATA,
        POP,
        STAT,
        MR,
        WAIT_END
    } state_t;

    localparam logic [3:0] SI_LOAD  = 4'(SI_WIDTH - 1);
    localparam logic [3:0] SOB_LOAD = 4'(SOB_WIDTH - 1);
    localparam logic [3:0] MR_LOAD  = 4'(MR_WIDTH - 1);

    logic        ioreq_r, rd_r, wr_r;
    logic [15:0] addr_r;
    logic        din0_r;

    state_t      state_q, state_n;
    logic [3:0]  cnt_q, cnt_n;
    logic        si_q, si_n;
    logic        sob_q, sob_n;
    logic        oeb_q, oeb_n;
    logic        mr_q, mr_n;
    logic        doe_q, doe_n;
    logic [7:0]  dout_q, dout_n;
    logic        ovf_q, ovf_n;
    logic        unf_q, unf_n;

    logic        sel;
    logic        port_ctl;
    logic [7:0]  stat_word;

    assign sel       = !ioreq_r && (addr_r[15:1] == BASE_ADDR[15:1]);
    assign port_ctl  = addr_r[0];
    assign stat_word = {ovf_q, unf_q, 3'b000, fifo_host_dir, fifo_slave_dir, fifo_host_dor};

    // Register the bus strobes, address and control bit once so decoding sees stable values
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            ioreq_r <= 1'b1;
            rd_r    <= 1'b1;
            wr_r    <= 1'b1;
            addr_r  <= 16'h0000;
            din0_r  <= 1'b0;
        end else begin
            ioreq_r <= IOREQ_B;
            rd_r    <= RD_B;
            wr_r    <= WR_B;
            addr_r  <= A;
            din0_r  <= D_in[0];
        end
    end

    // State, width counter, sticky flags and all output strobes
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            si_q    <= 1'b0;
            sob_q   <= 1'b1;
            oeb_q   <= 1'b1;
            mr_q    <= 1'b1;
            doe_q   <= 1'b0;
            dout_q  <= 8'h00;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            si_q    <= si_n;
            sob_q   <= sob_n;
            oeb_q   <= oeb_n;
            mr_q    <= mr_n;
            doe_q   <= doe_n;
            dout_q  <= dout_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
        end
    end

    // Next-state and next-output decode: one FIFO action per decoded bus cycle
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        si_n    = si_q;
        sob_n   = sob_q;
        oeb_n   = oeb_q;
        mr_n    = mr_q;
        doe_n   = doe_q;
        dout_n  = dout_q;
        ovf_n   = ovf_q;
        unf_n   = unf_q;
        case (state_q)
            IDLE: begin
                mr_n = 1'b0;
                if (sel && !port_ctl && !wr_r) begin
                    if (fifo_slave_dir) begin
                        si_n    = 1'b1;
                        cnt_n   = SI_LOAD;
                        state_n = PUSH;
                    end else begin
                        ovf_n   = 1'b1;
                        state_n = WAIT_END;
                    end
                end else if (sel && !port_ctl && !rd_r) begin
                    if (fifo_host_dor) begin
                        oeb_n   = 1'b0;
                        state_n = RD_DATA;
                    end else begin
                        unf_n   = 1'b1;
                        doe_n   = 1'b1;
                        dout_n  = 8'h00;
                        state_n = WAIT_END;
                    end
                end else if (sel && port_ctl && !rd_r) begin
                    doe_n   = 1'b1;
                    dout_n  = stat_word;
                    state_n = STAT;
                end else if (sel && port_ctl && !wr_r) begin
                    if (din0_r) begin
                        mr_n    = 1'b1;
                        cnt_n   = MR_LOAD;
                        ovf_n   = 1'b0;
                        unf_n   = 1'b0;
                        state_n = MR;
                    end else begin
                        state_n = WAIT_END;
                    end
                end
            end
            PUSH: begin
                if (wr_r) begin
                    si_n = 1'b0;
                end
                if (cnt_q == 4'd0) begin
                    si_n    = 1'b0;
                    state_n = WAIT_END;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            RD_DATA: begin
                if (rd_r) begin
                    oeb_n   = 1'b1;
                    sob_n   = 1'b0;
                    cnt_n   = SOB_LOAD;
                    state_n = POP;
                end
            end
            POP: begin
                if (cnt_q == 4'd0) begin
                    sob_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            STAT: begin
                if (rd_r) begin
                    doe_n   = 1'b0;
                    ovf_n   = 1'b0;
                    unf_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            MR: begin
                ovf_n = 1'b0;
                unf_n = 1'b0;
                if (cnt_q == 4'd0) begin
                    mr_n    = 1'b0;
                    state_n = WAIT_END;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            WAIT_END: begin
                if ((rd_r && wr_r) || ioreq_r) begin
                    doe_n   = 1'b0;
                    si_n    = 1'b0;
                    sob_n   = 1'b1;
                    oeb_n   = 1'b1;
                    mr_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign D_out           = dout_q;
    assign D_oe            = doe_q;
    assign host_fifo_si    = si_q;
    assign host_fifo_sob   = sob_q;
    assign host_fifo_oeb   = oeb_q;
    assign host_fifo_reset = mr_q;

endmodule

// File: tb/tb_cpc_host_fifo_ctrl.sv
// Self-checking bench for cpc_host_fifo_ctrl: directed Z80 I/O cycles
// followed by randomized ones, each scored against a per-bus-cycle model
// of expected strobe pulses, read data and sticky error flags.
module tb_cpc_host_fifo_ctrl;

    localparam logic [15:0] BASE = 16'hFD80;

    logic        CLK = 1'b0;
    logic        RESET_B;
    logic [15:0] A;
    logic [7:0]  D_in;
    logic        IOREQ_B, RD_B, WR_B;
    logic        fifo_host_dir, fifo_host_dor, fifo_slave_dir;
    logic [7:0]  D_out;
    logic        D_oe;
    logic        host_fifo_si, host_fifo_sob, host_fifo_oeb, host_fifo_reset;

    int total = 0;
    int bad   = 0;

    // Monitor-owned counters
    int   si_pulses = 0, si_cyc = 0, sob_pulses = 0, sob_cyc = 0;
    int   mr_cyc = 0, oeb_cyc = 0, doe_cyc = 0;
    logic prev_si = 1'b0, prev_sob = 1'b1, prev_doe = 1'b0;
    logic [7:0] first_dout = 8'h00, last_dout = 8'h00;
    logic contention = 1'b0;

    // Reference model sticky flags
    logic m_ovf = 1'b0, m_unf = 1'b0;

    cpc_host_fifo_ctrl dut (
        .CLK            (CLK),
        .RESET_B        (RESET_B),
        .A              (A),
        .D_in           (D_in),
        .IOREQ_B        (IOREQ_B),
        .RD_B           (RD_B),
        .WR_B           (WR_B),
        .fifo_host_dir  (fifo_host_dir),
        .fifo_host_dor  (fifo_host_dor),
        .fifo_slave_dir (fifo_slave_dir),
        .D_out          (D_out),
        .D_oe           (D_oe),
        .host_fifo_si   (host_fifo_si),
        .host_fifo_sob  (host_fifo_sob),
        .host_fifo_oeb  (host_fifo_oeb),
        .host_fifo_reset(host_fifo_reset)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Observe outputs on the falling edge: pulse counts, widths, read data, bus contention
    always @(negedge CLK) begin
        if (host_fifo_si) si_cyc <= si_cyc + 1;
        if (host_fifo_si && !prev_si) si_pulses <= si_pulses + 1;
        if (!host_fifo_sob) sob_cyc <= sob_cyc + 1;
        if (!host_fifo_sob && prev_sob) sob_pulses <= sob_pulses + 1;
        if (host_fifo_reset) mr_cyc <= mr_cyc + 1;
        if (!host_fifo_oeb) oeb_cyc <= oeb_cyc + 1;
        if (D_oe) begin
            doe_cyc   <= doe_cyc + 1;
            last_dout <= D_out;
            if (!prev_doe) first_dout <= D_out;
        end
        if (D_oe && !host_fifo_oeb) contention <= 1'b1;
        prev_si  <= host_fifo_si;
        prev_sob <= host_fifo_sob;
        prev_doe <= D_oe;
    end

    // Hard time limit so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Run one Z80 bus cycle, predict its effect from the decode rules, then score it
    task automatic apply_stimulus(input logic [15:0] addr, input logic [7:0] data,
                                  input logic is_write, input logic is_io, input int hold);
        int b_si_p, b_si_c, b_sob_p, b_sob_c, b_mr_c, b_oeb_c, b_doe_c;
        int e_si_p, e_si_c, e_sob_p, e_sob_c, e_mr_c, e_oeb_c, e_doe_c;
        logic [7:0] e_dout;
        logic in_win;
        e_si_p = 0; e_si_c = 0; e_sob_p = 0; e_sob_c = 0;
        e_mr_c = 0; e_oeb_c = 0; e_doe_c = 0; e_dout = 8'h00;
        in_win = is_io && (addr[15:1] == BASE[15:1]);
        if (in_win) begin
            if (!addr[0] && is_write) begin
                if (fifo_slave_dir) begin e_si_p = 1; e_si_c = 2; end
                else m_ovf = 1'b1;
            end else if (!addr[0] && !is_write) begin
                if (fifo_host_dor) begin e_oeb_c = hold; e_sob_p = 1; e_sob_c = 2; end
                else begin e_doe_c = hold; e_dout = 8'h00; m_unf = 1'b1; end
            end else if (addr[0] && !is_write) begin
                e_doe_c = hold;
                e_dout  = {m_ovf, m_unf, 3'b000, fifo_host_dir, fifo_slave_dir, fifo_host_dor};
                m_ovf = 1'b0; m_unf = 1'b0;
            end else if (data[0]) begin
                e_mr_c = 4; m_ovf = 1'b0; m_unf = 1'b0;
            end
        end

        @(posedge CLK); #1;
        b_si_p = si_pulses; b_si_c = si_cyc; b_sob_p = sob_pulses; b_sob_c = sob_cyc;
        b_mr_c = mr_cyc; b_oeb_c = oeb_cyc; b_doe_c = doe_cyc;
        A = addr; D_in = data; IOREQ_B = !is_io;
        if (is_write) WR_B = 1'b0; else RD_B = 1'b0;
        repeat (hold) @(posedge CLK);
        #1;
        IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1;
        repeat (12) @(posedge CLK);
        #1;

        check_output("si_pulses", si_pulses - b_si_p, e_si_p);
        check_output("si_width", si_cyc - b_si_c, e_si_c);
        check_output("sob_pulses", sob_pulses - b_sob_p, e_sob_p);
        check_output("sob_width", sob_cyc - b_sob_c, e_sob_c);
        check_output("mr_width", mr_cyc - b_mr_c, e_mr_c);
        check_output("oeb_width", oeb_cyc - b_oeb_c, e_oeb_c);
        check_output("doe_width", doe_cyc - b_doe_c, e_doe_c);
        if (e_doe_c > 0) begin
            check_output("dout_first", int'(first_dout), int'(e_dout));
            check_output("dout_last", int'(last_dout), int'(e_dout));
        end
        check_output("contention", int'(contention), 0);
    endtask

    task automatic set_flags(input logic hd, input logic sd, input logic dr);
        fifo_host_dir = hd; fifo_slave_dir = sd; fifo_host_dor = dr;
    endtask

    initial begin
        int found;
        int k;
        logic [15:0] ra;
        RESET_B = 1'b0; A = 16'h0000; D_in = 8'h00;
        IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1;
        set_flags(1'b0, 1'b1, 1'b1);
        $display("[TB] reset phase");
        repeat (3) @(posedge CLK);
        #1;
        check_output("rst_si", int'(host_fifo_si), 0);
        check_output("rst_sob", int'(host_fifo_sob), 1);
        check_output("rst_oeb", int'(host_fifo_oeb), 1);
        check_output("rst_mr", int'(host_fifo_reset), 1);
        check_output("rst_doe", int'(D_oe), 0);
        check_output("rst_dout", int'(D_out), 0);
        RESET_B = 1'b1;
        #1;
        check_output("rel_mr_hold", int'(host_fifo_reset), 1);
        @(posedge CLK); #1;
        check_output("rel_mr_drop", int'(host_fifo_reset), 0);
        check_output("rel_si", int'(host_fifo_si), 0);
        check_output("rel_sob", int'(host_fifo_sob), 1);
        check_output("rel_oeb", int'(host_fifo_oeb), 1);
        check_output("rel_doe", int'(D_oe), 0);

        $display("[TB] directed bus cycles");
        set_flags(1'b0, 1'b1, 1'b1);
        apply_stimulus(16'hFD80, 8'h5A, 1'b1, 1'b1, 3);
        set_flags(1'b0, 1'b0, 1'b1);
        apply_stimulus(16'hFD80, 8'h5A, 1'b1, 1'b1, 3);
        apply_stimulus(16'hFD81, 8'h00, 1'b0, 1'b1, 3);
        apply_stimulus(16'hFD81, 8'h00, 1'b0, 1'b1, 3);
        set_flags(1'b0, 1'b1, 1'b1);
        apply_stimulus(16'hFD80, 8'h00, 1'b0, 1'b1, 3);
        set_flags(1'b0, 1'b1, 1'b0);
        apply_stimulus(16'hFD80, 8'h00, 1'b0, 1'b1, 3);
        apply_stimulus(16'hFD81, 8'h00, 1'b0, 1'b1, 3);
        set_flags(1'b0, 1'b1, 1'b1);
        apply_stimulus(16'hFD81, 8'h00, 1'b0, 1'b1, 3);
        set_flags(1'b0, 1'b0, 1'b0);
        apply_stimulus(16'hFD80, 8'h11, 1'b1, 1'b1, 2);
        apply_stimulus(16'hFD80, 8'h00, 1'b0, 1'b1, 2);
        apply_stimulus(16'hFD81, 8'h01, 1'b1, 1'b1, 3);
        apply_stimulus(16'hFD81, 8'h00, 1'b0, 1'b1, 3);
        apply_stimulus(16'hFD81, 8'h00, 1'b1, 1'b1, 3);
        set_flags(1'b1, 1'b1, 1'b1);
        apply_stimulus(16'hFC80, 8'h01, 1'b1, 1'b1, 3);
        apply_stimulus(16'hFC80, 8'h00, 1'b0, 1'b1, 3);
        apply_stimulus(16'hFD80, 8'h33, 1'b1, 1'b0, 3);

        $display("[TB] reset during push");
        set_flags(1'b0, 1'b1, 1'b1);
        k = si_pulses;
        @(posedge CLK); #1;
        A = 16'hFD80; D_in = 8'hA5; IOREQ_B = 1'b0; WR_B = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (host_fifo_si) begin
                found = 1;
                break;
            end
        end
        check_output("push_start_seen", found, 1);
        RESET_B = 1'b0;
        #1;
        check_output("rst_mid_si", int'(host_fifo_si), 0);
        check_output("rst_mid_mr", int'(host_fifo_reset), 1);
        IOREQ_B = 1'b1; WR_B = 1'b1;
        m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge CLK); #1;
        RESET_B = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        check_output("rst_mid_no_pulse", si_pulses - k, 0);
        apply_stimulus(16'hFD81, 8'h00, 1'b0, 1'b1, 3);

        $display("[TB] randomized bus cycles");
        for (int n = 0; n < 80; n++) begin
            set_flags(1'($urandom), 1'($urandom), 1'($urandom));
            case ($urandom_range(0, 5))
                0: ra = 16'hFD80;
                1: ra = 16'hFD81;
                2: ra = 16'hFD80;
                3: ra = 16'hFD81;
                4: begin
                    ra = 16'($urandom);
                    if (ra[15:1] == BASE[15:1]) ra[9] = ~ra[9];
                end
                default: ra = {15'($urandom), 1'($urandom)};
            endcase
            apply_stimulus(ra, 8'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
                           $urandom_range(2, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpc_host_fifo_ctrl.md
Name: cpc_host_fifo_ctrl

Overview:
- CPLD-resident controller that sequences the host (CPC) side of the bidirectional FIFO link.
- Decodes Z80 I/O cycles at a two-port address window and turns host writes into FIFO shift-in pulses.
- Gates FIFO outputs onto the CPC data bus for host reads, then pops the word with a shift-out pulse.
- Serves a status/control register and sequences FIFO master reset; sits between the CPC edge connector signals and both FIFO pairs.

Parameters:
- BASE_ADDR, 16'hFD80, port window base; A[15:1] must equal BASE_ADDR[15:1]; A0=0 is the data port, A0=1 is the status/control port.
- SI_WIDTH, 2, CLK cycles host_fifo_si is held high per push (1..7).
- SOB_WIDTH, 2, CLK cycles host_fifo_sob is held low per pop (1..7).
- MR_WIDTH, 4, CLK cycles host_fifo_reset is held high for a soft reset (1..15).

Ports:
- CLK  in  1  CPC system clock (4 MHz); all state on rising edge.
- RESET_B  in  1  asynchronous active-low reset.
- A  in  16  Z80 address bus.
- D_in  in  8  CPC data bus, input side.
- IOREQ_B  in  1  Z80 I/O request, active low.
- RD_B  in  1  Z80 read strobe, active low.
- WR_B  in  1  Z80 write strobe, active low.
- fifo_host_dir  in  1  slave->host FIFO input-ready flag (unused by host logic; status only).
- fifo_host_dor  in  1  slave->host FIFO has data.
- fifo_slave_dir  in  1  host->slave FIFO has space.
- D_out  out  8  CPLD-driven data for status reads.
- D_oe  out  1  high = CPLD drives D_out onto the data bus.
- host_fifo_si  out  1  shift-in to host->slave FIFO, active high.
- host_fifo_sob  out  1  shift-out from slave->host FIFO, active low.
- host_fifo_oeb  out  1  slave->host FIFO output enable, active low.
- host_fifo_reset  out  1  FIFO master reset, active high.

Behaviour:
- Reset (RESET_B=0, async): state=IDLE; host_fifo_si=0, host_fifo_sob=1, host_fifo_oeb=1, host_fifo_reset=1, D_oe=0, D_out=0, ovf=0, unf=0. host_fifo_reset stays 1 for the first cycle after RESET_B rises, then goes 0.
- IOREQ_B/RD_B/WR_B are registered once on CLK. Cycle detection uses the registered values. A and D_in are sampled on the same edge. sel = IOREQ_B_r=0 and A[15:1]==BASE_ADDR[15:1].
- IDLE:
  - Data write: sel, A0=0, WR_B_r=0. If fifo_slave_dir=1: host_fifo_si=1 next cycle, go PUSH. Else set ovf, go WAIT_END.
  - Data read: sel, A0=0, RD_B_r=0. If fifo_host_dor=1: host_fifo_oeb=0 next cycle, go RD_DATA. Else set unf, D_oe=1 with D_out=8'h00, go WAIT_END.
  - Status read: sel, A0=1, RD_B_r=0. D_oe=1 next cycle with D_out={ovf,unf,3'b0,fifo_host_dir,fifo_slave_dir,fifo_host_dor}, go STAT.
  - Control write: sel, A0=1, WR_B_r=0. If D_in[0]=1: host_fifo_reset=1, go MR; else go WAIT_END.
- PUSH: hold si for SI_WIDTH cycles, then si=0 and go WAIT_END. si also drops early if WR_B_r returns 1; the width counter still expires before leaving.
- RD_DATA: oeb=0 while RD_B_r=0. When RD_B_r=1: oeb=1 and host_fifo_sob=0 next cycle, go POP.
- POP: sob low for SOB_WIDTH cycles, then sob=1 and go IDLE.
- STAT: D_out frozen at the value captured on entry. When RD_B_r=1: D_oe=0, clear ovf and unf, go IDLE.
- MR: reset high MR_WIDTH cycles; ovf and unf are cleared. Then go WAIT_END.
- WAIT_END: D_oe and other strobes deasserted once both RD_B_r=1 and WR_B_r=1 (or IOREQ_B_r=1); then go IDLE. Prevents double push/pop from one bus cycle.
- Exactly one FIFO action per Z80 I/O cycle. Out-of-window I/O and memory cycles are ignored in every state.
- At most one of D_oe=1 and host_fifo_oeb=0 at any time (bus contention rule; assertion in bench).
- ovf/unf are sticky. Simultaneous set (new error) and clear (status read end) cannot occur because both are single-state; reset dominates.
- RESET_B low mid-operation forces all outputs to reset values immediately. An in-flight si/sob pulse is truncated, and FIFO MR covers the partial transfer.

Test Plan:
- Reset release: RESET_B 0->1 -> host_fifo_reset=1 one cycle then 0; si=0, sob=1, oeb=1, D_oe=0.
- OUT &FD80,&5A with slave_dir=1 -> si high exactly 2 cycles, one pulse only; ovf=0. Repeat with slave_dir=0 -> no si, next status read returns bit7=1, and a following status read returns bit7=0.
- IN &FD80 with host_dor=1 -> oeb low for the RD_B low window; after RD_B high, sob low exactly 2 cycles. Repeat with dor=0 -> D_out=8'h00, D_oe=1, no sob, status bit6=1.
- IN &FD81 with dor=1, slave_dir=1, host_dir=0 -> D_out=8'h03 while RD_B low; D_oe falls the cycle after RD_B rises.
- OUT &FD81,&01 -> host_fifo_reset high 4 cycles; ovf/unf cleared. OUT &FD81,&00 -> no reset. OUT &FC80 -> no response at all.
- Reset mid-PUSH (RESET_B low on cycle 1 of si) -> si=0 immediately, state IDLE after release, no further pulse.
